matrix_frame_seq: RTL and testbench

MATRIX_FRAME_SEQ -- requirements
Module: matrix_frame_seq

---
 rtl/matrix_pkg.sv | 47 ++++
 rtl/matrix_fb.sv | 32 +++
 rtl/matrix_frame_seq.sv | 169 ++++++++++++++++
 tb/tb_matrix_frame_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the 8x8 LED matrix frame sequencer.
// Holds register addresses, the fixed initialisation words, the sequencer
// state type and a helper that maps an init index to its command word.
// Optional feature macro: MATRIX_INTENSITY_EN (adds a fifth intensity word).
package matrix_pkg;

    localparam logic [7:0] AddrDecodeMode  = 8'h09;
    localparam logic [7:0] AddrIntensity   = 8'h0A;
    localparam logic [7:0] AddrScanLimit   = 8'h0B;
    localparam logic [7:0] AddrShutdown    = 8'h0C;
    localparam logic [7:0] AddrDisplayTest = 8'h0F;

    localparam logic [15:0] InitShutdown    = {AddrShutdown, 8'h01};
    localparam logic [15:0] InitDisplayTest = {AddrDisplayTest, 8'h00};
    localparam logic [15:0] InitDecodeMode  = {AddrDecodeMode, 8'h00};
    localparam logic [15:0] InitScanLimit   = {AddrScanLimit, 8'h07};

    localparam int unsigned NumRows  = 8;
    localparam logic [3:0]  RowCount = 4'd8;

`ifdef MATRIX_INTENSITY_EN
    localparam logic [3:0] InitWords = 4'd5;
`else
    localparam logic [3:0] InitWords = 4'd4;
`endif

    typedef enum logic [1:0] {
        StInit,
        StRows,
        StWait
    } state_e;

    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] intensity);
        logic [15:0] w;
        case (idx)
            3'd0:    w = InitShutdown;
            3'd1:    w = InitDisplayTest;
            3'd2:    w = InitDecodeMode;
            3'd3:    w = InitScanLimit;
            3'd4:    w = {AddrIntensity, 4'h0, intensity};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/matrix_fb.sv
// 8x8 pixel framebuffer: one byte per row, synchronous write, combinational
// read. Synchronous active-high reset clears every row.
// Ports: clk_i, rst_i, wr_en_i/wr_row_i/wr_data_i (write port),
//        rd_row_i -> rd_data_o (read port).
module matrix_fb
    import matrix_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_row_i,
    input  logic [7:0] wr_data_i,
    input  logic [2:0] rd_row_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] rows_q [NumRows];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRows; i++) begin
                rows_q[i] <= 8'h00;
            end
        end else if (wr_en_i) begin
            rows_q[wr_row_i] <= wr_data_i;
        end
    end

    // A same-cycle write is not visible here until the next cycle.
    assign rd_data_o = rows_q[rd_row_i];

endmodule

// File: rtl/matrix_frame_seq.sv
// Frame sequencer for an 8x8 LED matrix driver. After reset (or a start
// request) it emits the initialisation command words, then one word per row
// {row+1, pixels}, then idles REFRESH_CYCLES cycles (or less if the
// framebuffer was written) before resending the rows.
// Optional feature macro: MATRIX_INTENSITY_EN adds intensity_in and a fifth
// init word {0x0A, 0x0, intensity_in}.
// Ports:
//   clk_in, reset_in (sync, active high)
//   wr_en_in, wr_row_in, wr_data_in : framebuffer write port
//   start_in                        : request re-initialisation
//   word_out, word_valid_out, word_ready_in : valid/ready command stream
//   busy_out                        : in init or row phase
//   frame_done_out                  : pulse after the last row transfers
module matrix_frame_seq
    import matrix_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 16000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        wr_en_in,
    input  logic [2:0]  wr_row_in,
    input  logic [7:0]  wr_data_in,
    input  logic        start_in,
`ifdef MATRIX_INTENSITY_EN
    input  logic [3:0]  intensity_in,
`endif
    input  logic        word_ready_in,
    output logic [15:0] word_out,
    output logic        word_valid_out,
    output logic        busy_out,
    output logic        frame_done_out
);

    localparam logic [23:0] RefreshLoad = 24'(REFRESH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;       // index of the next word to present
    logic [23:0] cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        dirty_q, dirty_d;
    logic        pend_q, pend_d;

    logic        fire;
    logic        load_slot;
    logic        begin_rows;
    logic [2:0]  rd_row;
    logic [7:0]  fb_data;
    logic [7:0]  row_addr;
    logic [3:0]  intensity;

`ifdef MATRIX_INTENSITY_EN
    assign intensity = intensity_in;
`else
    assign intensity = 4'h0;
`endif

    matrix_fb u_fb (
        .clk_i     (clk_in),
        .rst_i     (reset_in),
        .wr_en_i   (wr_en_in),
        .wr_row_i  (wr_row_in),
        .wr_data_i (wr_data_in),
        .rd_row_i  (rd_row),
        .rd_data_o (fb_data)
    );

    // Outside the row phase the only row ever fetched is row 0.
    assign rd_row    = (state_q == StRows) ? idx_q[2:0] : 3'd0;
    assign row_addr  = {4'h0, idx_q} + 8'd1;
    assign fire      = valid_q & word_ready_in;
    assign load_slot = ~valid_q | fire;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        dirty_d    = dirty_q | wr_en_in;
        pend_d     = pend_q | start_in;
        begin_rows = 1'b0;

        if (fire) begin
            valid_d = 1'b0;
        end

        if (load_slot) begin
            if (start_in || pend_q) begin
                state_d = StInit;
                word_d  = init_word(3'd0, intensity);
                valid_d = 1'b1;
                idx_d   = 4'd1;
                pend_d  = 1'b0;
            end else begin
                unique case (state_q)
                    StInit: begin
                        if (idx_q < InitWords) begin
                            word_d  = init_word(idx_q[2:0], intensity);
                            valid_d = 1'b1;
                            idx_d   = idx_q + 4'd1;
                        end else begin
                            begin_rows = 1'b1;
                        end
                    end
                    StRows: begin
                        if (idx_q < RowCount) begin
                            word_d  = {row_addr, fb_data};
                            valid_d = 1'b1;
                            idx_d   = idx_q + 4'd1;
                        end else begin
                            state_d = StWait;
                            cnt_d   = RefreshLoad;
                            done_d  = 1'b1;
                        end
                    end
                    StWait: begin
                        if (dirty_q || cnt_q == 24'd0) begin
                            begin_rows = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 24'd1;
                        end
                    end
                    default: state_d = StInit;
                endcase
            end
        end

        if (begin_rows) begin
            state_d = StRows;
            word_d  = {8'h01, fb_data};
            valid_d = 1'b1;
            idx_d   = 4'd1;
            // A write landing as rows begin must still trigger a resend.
            dirty_d = wr_en_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= StInit;
            idx_q   <= 4'd0;
            cnt_q   <= 24'd0;
            word_q  <= 16'h0000;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            dirty_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            dirty_q <= dirty_d;
            pend_q  <= pend_d;
        end
    end

    assign word_out       = word_q;
    assign word_valid_out = valid_q;
    assign busy_out       = (state_q == StInit) || (state_q == StRows);
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_matrix_frame_seq.sv
// Self-checking bench for matrix_frame_seq. A framebuffer model and the list
// of init words produce the expected command stream for each frame; ready
// is randomised in some frames and words are checked on every transfer.
module tb_matrix_frame_seq;

    localparam int unsigned Refresh = 20;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        wr_en_in;
    logic [2:0]  wr_row_in;
    logic [7:0]  wr_data_in;
    logic        start_in;
    logic        word_ready_in;
    logic [15:0] word_out;
    logic        word_valid_out;
    logic        busy_out;
    logic        frame_done_out;
`ifdef MATRIX_INTENSITY_EN
    logic [3:0]  intensity_in;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  fb_model [8];
    logic [15:0] init_list [$];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    matrix_frame_seq #(
        .REFRESH_CYCLES (Refresh)
    ) dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .wr_en_in       (wr_en_in),
        .wr_row_in      (wr_row_in),
        .wr_data_in     (wr_data_in),
        .start_in       (start_in),
`ifdef MATRIX_INTENSITY_EN
        .intensity_in   (intensity_in),
`endif
        .word_ready_in  (word_ready_in),
        .word_out       (word_out),
        .word_valid_out (word_valid_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < 8; r++) fb_model[r] = 8'h00;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (word_valid_out !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        n_checks++;
        if (word_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait_valid: valid=%b after %0d cycles, required 1", tag,
                     word_valid_out, n);
        end
    endtask

    // Runs one frame from the current point; checks words, holds, bubbles and done.
    task automatic run_frame(input bit with_init, input int skip, input int pct,
                             input int coll_row, input logic [7:0] coll_data,
                             input string tag);
        int          got;
        int          budget;
        bit          held;
        bit          prev_xfer;
        bit          rdy;
        logic [15:0] held_w;
        exp_q.delete();
        if (with_init) begin
            foreach (init_list[i]) exp_q.push_back(init_list[i]);
        end
        for (int r = 0; r < 8; r++) exp_q.push_back({8'(r + 1), fb_model[r]});
        got = skip;
        budget = 3000;
        held = 0;
        prev_xfer = 0;
        held_w = '0;
        while (got < exp_q.size() && budget > 0) begin
            if (held) begin
                n_checks++;
                if (word_valid_out !== 1'b1 || word_out !== held_w) begin
                    n_fail++;
                    $display("FAIL %s hold: valid=%b word=%h, required valid=1 word=%h",
                             tag, word_valid_out, word_out, held_w);
                end
            end
            if (prev_xfer) begin
                n_checks++;
                if (word_valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s bubble: valid=%b after transfer %0d, required 1",
                             tag, word_valid_out, got);
                end
            end
            if (word_valid_out === 1'b1) begin
                n_checks++;
                if (busy_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy: busy=%b while presenting, required 1", tag, busy_out);
                end
            end
            rdy = ($urandom_range(99) < pct);
            word_ready_in = rdy;
            wr_en_in = 1'b0;
            prev_xfer = 0;
            held = 0;
            if (word_valid_out === 1'b1 && rdy) begin
                n_checks++;
                if (word_out !== exp_q[got]) begin
                    n_fail++;
                    $display("FAIL %s word[%0d]: got %h, required %h", tag, got, word_out,
                             exp_q[got]);
                end
                // Write the row being captured on this very edge.
                if (coll_row > 0 && got == exp_q.size() - 8 + coll_row - 1) begin
                    wr_en_in = 1'b1;
                    wr_row_in = 3'(coll_row);
                    wr_data_in = coll_data;
                end
                got++;
                prev_xfer = 1;
            end else if (word_valid_out === 1'b1) begin
                held = 1;
                held_w = word_out;
            end
            cyc();
            budget--;
        end
        wr_en_in = 1'b0;
        word_ready_in = 1'b0;
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d of %0d words, required all", tag, got, exp_q.size());
        end
        if (coll_row > 0) fb_model[coll_row] = coll_data;
        n_checks++;
        if (frame_done_out !== 1'b1 || word_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: done=%b valid=%b busy=%b, required 1 0 0", tag,
                     frame_done_out, word_valid_out, busy_out);
        end
        cyc();
        n_checks++;
        if (frame_done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", tag,
                     frame_done_out);
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (word_valid_out !== 1'b0 || word_out !== 16'h0000 || busy_out !== 1'b1 ||
                frame_done_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: valid=%b word=%h busy=%b done=%b, required 0 0000 1 0",
                         word_valid_out, word_out, busy_out, frame_done_out);
            end
        end
        reset_in = 1'b0;
        clear_model();
        cyc();
        n_checks++;
        if (word_valid_out !== 1'b1 || word_out !== 16'h0C01) begin
            n_fail++;
            $display("FAIL first_word: valid=%b word=%h, required 1 0c01", word_valid_out,
                     word_out);
        end
    endtask

    task automatic test_first_frame();
        run_frame(1'b1, 0, 100, 0, 8'h00, "first_frame");
    endtask

    task automatic test_refresh();
        int gap = 1;
        while (word_valid_out !== 1'b1 && gap < 100) begin
            gap++;
            cyc();
        end
        n_checks++;
        if (gap != Refresh) begin
            n_fail++;
            $display("FAIL refresh_gap: %0d idle cycles, required %0d", gap, Refresh);
        end
        run_frame(1'b0, 0, 100, 0, 8'h00, "refresh_frame");
    endtask

    task automatic test_early_frame();
        int         n = 0;
        logic [2:0] r;
        logic [7:0] d;
        cyc();
        r = 3'($urandom_range(7));
        d = 8'($urandom_range(1, 255));
        wr_en_in = 1'b1;
        wr_row_in = r;
        wr_data_in = d;
        cyc();
        wr_en_in = 1'b0;
        fb_model[r] = d;
        while (word_valid_out !== 1'b1 && n < 5) begin
            cyc();
            n++;
        end
        n_checks++;
        if (word_valid_out !== 1'b1 || n > 2 || word_out !== {8'h01, fb_model[0]}) begin
            n_fail++;
            $display("FAIL early_frame: valid=%b word=%h after %0d cycles, required 1 %h within 2",
                     word_valid_out, word_out, n, {8'h01, fb_model[0]});
        end
        run_frame(1'b0, 0, 100, 0, 8'h00, "early_frame");
    endtask

    task automatic test_backpressure();
        logic [2:0] rr;
        reset_in = 1'b1;
        cyc();
        cyc();
        reset_in = 1'b0;
        clear_model();
        cyc();
        word_ready_in = 1'b1;
        cyc();
        word_ready_in = 1'b0;
        rr = 3'($urandom_range(3, 7));
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (word_valid_out !== 1'b1 || word_out !== 16'h0F00) begin
                n_fail++;
                $display("FAIL stall[%0d]: valid=%b word=%h, required 1 0f00", i,
                         word_valid_out, word_out);
            end
            wr_en_in = (i < 2);
            wr_row_in = (i == 0) ? 3'd2 : rr;
            wr_data_in = (i == 0) ? 8'h99 : 8'h5A;
            cyc();
        end
        wr_en_in = 1'b0;
        fb_model[2] = 8'h99;
        fb_model[rr] = 8'h5A;
        word_ready_in = 1'b1;
        cyc();
        word_ready_in = 1'b0;
        n_checks++;
        if (word_valid_out !== 1'b1 || word_out !== 16'h0900) begin
            n_fail++;
            $display("FAIL stall_resume: valid=%b word=%h, required 1 0900", word_valid_out,
                     word_out);
        end
        run_frame(1'b1, 2, 50, 0, 8'h00, "backpressure");
    endtask

    task automatic test_collision();
        int         n = 0;
        int         r;
        logic [7:0] d;
        r = $urandom_range(1, 7);
        d = fb_model[r] ^ 8'($urandom_range(1, 255));
        run_frame(1'b0, 0, 100, r, d, "collision");
        while (word_valid_out !== 1'b1 && n < 5) begin
            cyc();
            n++;
        end
        n_checks++;
        if (word_valid_out !== 1'b1 || n > 1) begin
            n_fail++;
            $display("FAIL collision_resend: valid=%b after %0d cycles, required 1 within 1",
                     word_valid_out, n);
        end
        run_frame(1'b0, 0, 100, 0, 8'h00, "collision_resend");
    endtask

    task automatic test_start_reinit();
        int          n = 0;
        logic [15:0] exp4;
        exp4 = {8'h05, fb_model[4]};
        wait_valid("reinit");
        while (!(word_valid_out === 1'b1 && word_out === exp4) && n < 50) begin
            word_ready_in = 1'b1;
            cyc();
            n++;
        end
        word_ready_in = 1'b0;
        start_in = 1'b1;
        cyc();
        start_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (word_valid_out !== 1'b1 || word_out !== exp4) begin
                n_fail++;
                $display("FAIL reinit_hold[%0d]: valid=%b word=%h, required 1 %h", i,
                         word_valid_out, word_out, exp4);
            end
            cyc();
        end
        word_ready_in = 1'b1;
        cyc();
        word_ready_in = 1'b0;
        n_checks++;
        if (word_valid_out !== 1'b1 || word_out !== 16'h0C01) begin
            n_fail++;
            $display("FAIL reinit_next: valid=%b word=%h, required 1 0c01", word_valid_out,
                     word_out);
        end
        run_frame(1'b1, 0, 100, 0, 8'h00, "reinit_frame");
    endtask

    task automatic test_start_same_cycle();
        wait_valid("start_xfer");
        word_ready_in = 1'b1;
        cyc();
        start_in = 1'b1;
        cyc();
        start_in = 1'b0;
        word_ready_in = 1'b0;
        n_checks++;
        if (word_valid_out !== 1'b1 || word_out !== 16'h0C01) begin
            n_fail++;
            $display("FAIL start_xfer_next: valid=%b word=%h, required 1 0c01", word_valid_out,
                     word_out);
        end
        run_frame(1'b1, 0, 60, 0, 8'h00, "start_xfer_frame");
    endtask

    task automatic test_reset_mid();
        wait_valid("reset_mid");
        word_ready_in = 1'b1;
        cyc();
        reset_in = 1'b1;
        cyc();
        n_checks++;
        if (word_valid_out !== 1'b0 || word_out !== 16'h0000 || busy_out !== 1'b1 ||
            frame_done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b word=%h busy=%b done=%b, required 0 0000 1 0",
                     word_valid_out, word_out, busy_out, frame_done_out);
        end
        cyc();
        reset_in = 1'b0;
        word_ready_in = 1'b0;
        clear_model();
        cyc();
        run_frame(1'b1, 0, 100, 0, 8'h00, "after_reset");
    endtask

    initial begin
        reset_in = 1'b1;
        wr_en_in = 1'b0;
        wr_row_in = 3'd0;
        wr_data_in = 8'h00;
        start_in = 1'b0;
        word_ready_in = 1'b0;
        init_list = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07};
`ifdef MATRIX_INTENSITY_EN
        intensity_in = 4'($urandom_range(15));
        init_list.push_back({8'h0A, 4'h0, intensity_in});
`endif
        clear_model();

        test_reset();
        test_first_frame();
        test_refresh();
        test_early_frame();
        test_backpressure();
        test_collision();
        test_start_reinit();
        test_start_same_cycle();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
